port_out_decoder: RTL and testbench

//  Write-side companion of the PicoBlaze input-port selector: decodes Port_ID on Write_Strobe
//  and captures Out_Port into output registers, one-cycle strobes and a small command FIFO.

---
 rtl/port_out_decoder_pkg.sv | 33 +++
 rtl/port_out_decoder_cmd_fifo.sv | 73 +++++++
 rtl/port_out_decoder.sv | 92 +++++++++
 tb/tb_port_out_decoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/port_out_decoder_pkg.sv
// Shared PicoBlaze port map for the input-side selector and the write-side decoder.
// Keeping both maps here prevents the two sides from claiming the same address.
package port_out_decoder_pkg;

    // Write map
    localparam logic [7:0] PORT_WR_DATA  = 8'h01;
    localparam logic [7:0] PORT_WR_CTRL  = 8'h02;
    localparam logic [7:0] PORT_WR_ACK   = 8'h03;
    localparam logic [7:0] PORT_WR_CMD   = 8'h04;
    localparam logic [7:0] PORT_WR_FLUSH = 8'h08;

    // Read map (owned by the input-side selector)
    localparam logic [7:0] PORT_RD_KEY    = 8'h05;
    localparam logic [7:0] PORT_RD_STATUS = 8'h06;
    localparam logic [7:0] PORT_RD_AUX    = 8'h07;

    localparam int CMD_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        WR_NONE,
        WR_DATA,
        WR_CTRL,
        WR_ACK,
        WR_CMD,
        WR_FLUSH,
        WR_UNMAPPED
    } wr_target_e;

    function automatic logic is_read_port(input logic [7:0] id);
        return (id == PORT_RD_KEY) || (id == PORT_RD_STATUS) || (id == PORT_RD_AUX);
    endfunction

endpackage

// File: rtl/port_out_decoder_cmd_fifo.sv
// Synchronous show-ahead command FIFO with push, pop and flush; head is visible
// one cycle after the first push into an empty FIFO.
module port_out_decoder_cmd_fifo #(
    parameter int  FIFO_DEPTH = 4,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int LW         = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop_req,
    input  logic          flush,
    output logic [7:0]    head_data,
    output logic          head_valid,
    output logic          full,
    output logic [LW-1:0] level,
    output logic          drop
);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          pop;
    logic          push_ok;

    assign head_valid = (level_q != '0);
    assign full       = (level_q == LW'(FIFO_DEPTH));
    assign level      = level_q;
    assign head_data  = mem_q[rd_ptr_q];
    assign pop        = head_valid & pop_req;
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign push_ok    = push & (~full | pop);
    assign drop       = push & ~push_ok;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            level_d = level_q + LW'(push_ok) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/port_out_decoder.sv
// PicoBlaze write-side decoder: output registers, key-acknowledge strobe,
// command FIFO and a write-error pulse for unmapped or dropped writes.
module port_out_decoder
    import port_out_decoder_pkg::*;
#(
    parameter logic [7:0] ADDR_DATA  = PORT_WR_DATA,
    parameter logic [7:0] ADDR_CTRL  = PORT_WR_CTRL,
    parameter logic [7:0] ADDR_ACK   = PORT_WR_ACK,
    parameter logic [7:0] ADDR_CMD   = PORT_WR_CMD,
    parameter logic [7:0] ADDR_FLUSH = PORT_WR_FLUSH,
    parameter int         FIFO_DEPTH = CMD_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   Port_ID,
    input  logic                         Write_Strobe,
    input  logic [7:0]                   Out_Port,
    output logic [7:0]                   Reg_Data,
    output logic [7:0]                   Reg_Ctrl,
    output logic                         Ack_Key,
    output logic [7:0]                   Cmd_Data,
    output logic                         Cmd_Valid,
    input  logic                         Cmd_Ready,
    output logic                         Fifo_Full,
    output logic [$clog2(FIFO_DEPTH):0]  Fifo_Level,
    output logic                         Write_Error
);

    wr_target_e wr_tgt;
    logic [7:0] reg_data_q, reg_data_d;
    logic [7:0] reg_ctrl_q, reg_ctrl_d;
    logic       ack_key_q, ack_key_d;
    logic       write_error_q, write_error_d;
    logic       fifo_drop;

    always_comb begin
        wr_tgt = WR_NONE;
        if (Write_Strobe) begin
            case (Port_ID)
                ADDR_DATA:  wr_tgt = WR_DATA;
                ADDR_CTRL:  wr_tgt = WR_CTRL;
                ADDR_ACK:   wr_tgt = WR_ACK;
                ADDR_CMD:   wr_tgt = WR_CMD;
                ADDR_FLUSH: wr_tgt = WR_FLUSH;
                default:    wr_tgt = WR_UNMAPPED;
            endcase
        end
    end

    port_out_decoder_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (wr_tgt == WR_CMD),
        .push_data  (Out_Port),
        .pop_req    (Cmd_Ready),
        .flush      (wr_tgt == WR_FLUSH),
        .head_data  (Cmd_Data),
        .head_valid (Cmd_Valid),
        .full       (Fifo_Full),
        .level      (Fifo_Level),
        .drop       (fifo_drop)
    );

    always_comb begin
        reg_data_d    = (wr_tgt == WR_DATA) ? Out_Port : reg_data_q;
        reg_ctrl_d    = (wr_tgt == WR_CTRL) ? Out_Port : reg_ctrl_q;
        ack_key_d     = (wr_tgt == WR_ACK);
        write_error_d = (wr_tgt == WR_UNMAPPED) | fifo_drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_data_q    <= '0;
            reg_ctrl_q    <= '0;
            ack_key_q     <= 1'b0;
            write_error_q <= 1'b0;
        end else begin
            reg_data_q    <= reg_data_d;
            reg_ctrl_q    <= reg_ctrl_d;
            ack_key_q     <= ack_key_d;
            write_error_q <= write_error_d;
        end
    end

    assign Reg_Data    = reg_data_q;
    assign Reg_Ctrl    = reg_ctrl_q;
    assign Ack_Key     = ack_key_q;
    assign Write_Error = write_error_q;

endmodule

// File: tb/tb_port_out_decoder.sv
// Bench for port_out_decoder: directed scenarios plus randomized traffic, all
// compared against a queue-based model of the port map.
module tb_port_out_decoder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Port_ID;
    logic       Write_Strobe;
    logic [7:0] Out_Port;
    logic [7:0] Reg_Data;
    logic [7:0] Reg_Ctrl;
    logic       Ack_Key;
    logic [7:0] Cmd_Data;
    logic       Cmd_Valid;
    logic       Cmd_Ready;
    logic       Fifo_Full;
    logic [2:0] Fifo_Level;
    logic       Write_Error;

    always #5 clk = ~clk;

    port_out_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .Port_ID      (Port_ID),
        .Write_Strobe (Write_Strobe),
        .Out_Port     (Out_Port),
        .Reg_Data     (Reg_Data),
        .Reg_Ctrl     (Reg_Ctrl),
        .Ack_Key      (Ack_Key),
        .Cmd_Data     (Cmd_Data),
        .Cmd_Valid    (Cmd_Valid),
        .Cmd_Ready    (Cmd_Ready),
        .Fifo_Full    (Fifo_Full),
        .Fifo_Level   (Fifo_Level),
        .Write_Error  (Write_Error)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_data;
    logic [7:0] m_ctrl;
    logic       m_ack;
    logic       m_err;
    logic [7:0] m_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input logic [7:0] id, input bit ws,
                              input logic [7:0] d, input bit rdy);
        bit pop;
        bit do_push;
        bit do_flush;
        if (rst) begin
            m_data = 8'h00;
            m_ctrl = 8'h00;
            m_ack  = 1'b0;
            m_err  = 1'b0;
            m_q.delete();
            return;
        end
        pop      = (m_q.size() > 0) && rdy;
        do_push  = 1'b0;
        do_flush = 1'b0;
        m_ack    = ws && (id == 8'h03);
        m_err    = 1'b0;
        if (ws) begin
            case (id)
                8'h01: m_data = d;
                8'h02: m_ctrl = d;
                8'h03: ;
                8'h04: if (m_q.size() < DEPTH || pop) do_push = 1'b1; else m_err = 1'b1;
                8'h08: do_flush = 1'b1;
                default: m_err = 1'b1;
            endcase
        end
        if (do_flush) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back(d);
        end
    endtask

    task automatic check_all();
        check("reg_data", Reg_Data, m_data);
        check("reg_ctrl", Reg_Ctrl, m_ctrl);
        check("ack_key", Ack_Key, m_ack);
        check("write_error", Write_Error, m_err);
        check("cmd_valid", Cmd_Valid, m_q.size() > 0);
        check("fifo_level", Fifo_Level, m_q.size());
        check("fifo_full", Fifo_Full, m_q.size() == DEPTH);
        if (m_q.size() > 0) check("cmd_data", Cmd_Data, m_q[0]);
        else check("cmd_data_known", $isunknown(Cmd_Data), 0);
    endtask

    // Drive one cycle of inputs, advance the model, then sample 1ns after the edge.
    task automatic cyc(input bit rst, input logic [7:0] id, input bit ws,
                       input logic [7:0] d, input bit rdy);
        reset        = rst;
        Port_ID      = id;
        Write_Strobe = ws;
        Out_Port     = d;
        Cmd_Ready    = rdy;
        model_step(rst, id, ws, d, rdy);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [7:0] vals[4];
        int r;
        reset = 1'b1; Port_ID = '0; Write_Strobe = 1'b0; Out_Port = '0; Cmd_Ready = 1'b0;

        cyc(1, 8'h00, 0, 8'h00, 0);
        cyc(1, 8'h04, 1, 8'hEE, 1);
        check("rst_level", Fifo_Level, 0);

        // Register writes and a strobe-less access
        cyc(0, 8'h01, 1, 8'hA5, 0);
        cyc(0, 8'h02, 1, 8'h3C, 0);
        check("t1_data", Reg_Data, 8'hA5);
        check("t1_ctrl", Reg_Ctrl, 8'h3C);
        cyc(0, 8'h01, 0, 8'hFF, 0);
        check("t1_nostrobe", Reg_Data, 8'hA5);

        // Back-to-back acknowledge
        cyc(0, 8'h03, 1, 8'h00, 0);
        check("t2_ack1", Ack_Key, 1);
        cyc(0, 8'h03, 1, 8'h00, 0);
        check("t2_ack2", Ack_Key, 1);
        cyc(0, 8'h00, 0, 8'h00, 0);
        check("t2_ack3", Ack_Key, 0);

        // Fill, overflow, drain
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        foreach (vals[i]) cyc(0, 8'h04, 1, vals[i], 0);
        check("t3_full", Fifo_Full, 1);
        cyc(0, 8'h04, 1, 8'h55, 0);
        check("t3_ovf_err", Write_Error, 1);
        check("t3_ovf_lvl", Fifo_Level, 4);
        cyc(0, 8'h00, 0, 8'h00, 0);
        check("t3_err_pulse", Write_Error, 0);
        foreach (vals[i]) begin
            check("t3_order", Cmd_Data, vals[i]);
            cyc(0, 8'h00, 0, 8'h00, 1);
        end
        check("t3_empty", Cmd_Valid, 0);

        // Push into full FIFO while popping
        for (int i = 1; i <= 4; i++) cyc(0, 8'h04, 1, 8'(i), 0);
        cyc(0, 8'h04, 1, 8'h66, 1);
        check("t4_no_err", Write_Error, 0);
        check("t4_level", Fifo_Level, 4);
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 8'h00, 1);
        check("t4_last", Cmd_Data, 8'h66);

        // Flush overriding pop, then a write to a read-only port
        cyc(0, 8'h00, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) cyc(0, 8'h04, 1, 8'h70 + 8'(i), 0);
        cyc(0, 8'h08, 1, 8'h00, 1);
        check("t5_flush_lvl", Fifo_Level, 0);
        check("t5_flush_vld", Cmd_Valid, 0);
        cyc(0, 8'h06, 1, 8'h77, 0);
        check("t5_unmapped", Write_Error, 1);
        check("t5_reg_keep", Reg_Data, 8'hA5);

        // Reset during traffic
        cyc(0, 8'h04, 1, 8'h81, 0);
        cyc(0, 8'h04, 1, 8'h82, 0);
        cyc(0, 8'h03, 1, 8'h00, 0);
        cyc(1, 8'h04, 1, 8'h99, 1);
        check("t6_level", Fifo_Level, 0);
        check("t6_ack", Ack_Key, 0);
        check("t6_data", Reg_Data, 8'h00);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 11);
            cyc($urandom_range(0, 99) == 0,
                (r <= 8) ? 8'(r) : 8'($urandom),
                $urandom_range(0, 3) != 0,
                8'($urandom),
                $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
